mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameter OP_W, default 4, opcode width; SHALL be at least 4.
REQ-002 Parameter FLAG_W, default 2, number of condition flags (bit0 Z, bit1 N); SHALL be at least 2.
REQ-003 Parameter LR_DEPTH, default 4, link-stack capacity tracked for call/return.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 op  in  OP_W  opcode from the instruction bus; sampled only at fetch completion.
REQ-008 flags  in  FLAG_W  condition flags from the ALU.
REQ-009 cond_idx  in  $clog2(FLAG_W)  selects the flag tested by op 10; sampled with op.
REQ-010 mem_ready  in  1  memory handshake completion for fetch, load and store.
REQ-011 ifetch  out  1  instruction fetch request.
REQ-012 ir_we  out  1  instruction register load strobe.
REQ-013 pc_we  out  1  PC update strobe.
REQ-014 rfwe  out  4  register write enables: bit3 LR, bit2 N, bit1 Z, bit0 RF.
REQ-015 dmwe / dmre  out  1 each  data memory write and read request.
REQ-016 outwe  out  1  output port write.
REQ-017 branchSel  out  2  next-PC select: 0 pc+2, 1 target, 2 link.
REQ-018 wbSel / portSel  out  1 each  writeback-from-memory select and input-port select.
REQ-019 lr_depth  out  $clog2(LR_DEPTH+1)  current link-stack occupancy.
REQ-020 stack_err  out  1  sticky flag for link-stack overflow or underflow.
REQ-021 state  out  3  current FSM state encoding, for debug.

Function
REQ-022 FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT. Outputs SHALL be decoded from the state and the latched opcode.
REQ-023 FETCH: ifetch=1 while waiting. When mem_ready=1, ir_we=1 for that cycle, op and cond_idx are latched, and the next state is DECODE.
REQ-024 DECODE: one cycle, all strobes 0, next state EXEC.
REQ-025 EXEC, ALU ops: ops 1–3 SHALL drive rfwe=0111; ops 4, 5, 7, 8 SHALL drive rfwe=0001; op 7 also drives portSel=1; op 6 drives outwe=1. Each of these asserts pc_we=1 with branchSel=0 and returns to FETCH.
REQ-026 EXEC, branches: op 9 drives branchSel=1. Op 10 drives branchSel=1 if flags[cond_idx]=1, else 0. Op 11 drives branchSel=1, rfwe=1000 and a push. Op 12 drives branchSel=2 and a pop. All assert pc_we and return to FETCH.
REQ-027 EXEC, other ops: op 15 drives rfwe=0001, wbSel=1 and pc_we. Op 0 drives pc_we only. Ops 13 and 14 go to MEM with no pc_we.
REQ-028 MEM: op 13 asserts dmre and op 14 asserts dmwe, held until mem_ready=1. On completion, op 13 goes to WB; op 14 asserts pc_we with branchSel=0 and goes to FETCH.
REQ-029 WB: rfwe=0001, wbSel=1, pc_we=1, next state FETCH.
REQ-030 Push when lr_depth<LR_DEPTH: increment. When full: no increment, stack_err set, branch still taken.
REQ-031 Pop when lr_depth>0: decrement. When empty: stack_err set, branchSel=0 instead of 2.
REQ-032 At most one strobe group is active per cycle; no strobe is asserted in DECODE or HALT.
REQ-033 Opcodes of 16 and above are handled per REQ-037.

Reset
REQ-034 rst_n low SHALL asynchronously force state=FETCH, lr_depth=0, stack_err=0, latched op=0, and every strobe to 0; this applies mid-handshake as well.
REQ-035 After rst_n deasserts, the first ifetch SHALL assert in the first cycle.

Configuration
REQ-036 Macro MC_CTRL_ILLEGAL_TRAP_EN controls illegal-opcode handling.
REQ-037 With MC_CTRL_ILLEGAL_TRAP_EN defined, opcodes of 16 and above move EXEC to HALT, which holds with all strobes 0 until reset. Without it, they behave as op 0.

Structure
REQ-038 Package ctrl_pkg SHALL hold the opcode localparams, the state enum, the rfwe bit indices and the branchSel codes.
REQ-039 Sub-module ctrl_link_tracker SHALL hold the lr_depth counter and stack_err logic, with push/pop in and depth/err out.

Verification
REQ-040 op=1, mem_ready=1 at fetch -> EXEC shows rfwe=0111, pc_we=1, branchSel=0; fetch-to-fetch is 3 cycles.
REQ-041 op=13, mem_ready held low 3 cycles in MEM -> dmre held 4 cycles, then WB with rfwe=0001, wbSel=1.
REQ-042 op=10 with cond_idx=1: flags=10 gives branchSel=1; flags=01 gives branchSel=0.
REQ-043 Five op=11 calls with LR_DEPTH=4 -> lr_depth=4 and stack_err=1 after the fifth; op=12 then gives lr_depth=3 and branchSel=2.
REQ-044 op=12 at lr_depth=0 -> branchSel=0, stack_err=1, lr_depth stays 0.
REQ-045 rst_n low during MEM with dmwe=1 -> dmwe=0 and state=FETCH immediately. With OP_W=5 and the trap enabled, op=20 leads to HALT.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the micro-coded control FSM: opcodes, state codes,
// register-write-enable bit positions, next-PC select codes and strobe bundle.
package ctrl_pkg;

    // Opcodes (low four bits of the latched instruction opcode)
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_OUT  = 4'd6;
    localparam logic [3:0] OP_IN   = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_BCC  = 4'd10;
    localparam logic [3:0] OP_CALL = 4'd11;
    localparam logic [3:0] OP_RET  = 4'd12;
    localparam logic [3:0] OP_LD   = 4'd13;
    localparam logic [3:0] OP_ST   = 4'd14;
    localparam logic [3:0] OP_LDI  = 4'd15;

    // FSM state encoding (also exported on the debug state port)
    typedef logic [2:0] state_t;
    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;

    // rfwe bit positions
    localparam int RFWE_RF = 0;
    localparam int RFWE_Z  = 1;
    localparam int RFWE_N  = 2;
    localparam int RFWE_LR = 3;

    // branchSel codes
    localparam logic [1:0] BSEL_SEQ  = 2'd0;  // pc+2
    localparam logic [1:0] BSEL_TGT  = 2'd1;  // branch target
    localparam logic [1:0] BSEL_LINK = 2'd2;  // link register

    // All controller strobes as one bundle so reset gating is a single mux
    typedef struct packed {
        logic       ifetch;
        logic       ir_we;
        logic       pc_we;
        logic [3:0] rfwe;
        logic       dmwe;
        logic       dmre;
        logic       outwe;
        logic [1:0] branchSel;
        logic       wbSel;
        logic       portSel;
    } ctrl_strobes_t;

endpackage

// File: rtl/mc_controller_if.sv
// Instruction/data bus and datapath strobe bundle between the controller
// (master) and the datapath/memory side (slave).
interface mc_controller_if #(
    parameter int OP_W   = 4,
    parameter int FLAG_W = 2
);
    logic [OP_W-1:0]           op;
    logic [FLAG_W-1:0]         flags;
    logic [$clog2(FLAG_W)-1:0] cond_idx;
    logic                      mem_ready;

    logic       ifetch;
    logic       ir_we;
    logic       pc_we;
    logic [3:0] rfwe;
    logic       dmwe;
    logic       dmre;
    logic       outwe;
    logic [1:0] branchSel;
    logic       wbSel;
    logic       portSel;

    modport master (
        input  op, flags, cond_idx, mem_ready,
        output ifetch, ir_we, pc_we, rfwe, dmwe, dmre, outwe, branchSel, wbSel, portSel
    );

    modport slave (
        output op, flags, cond_idx, mem_ready,
        input  ifetch, ir_we, pc_we, rfwe, dmwe, dmre, outwe, branchSel, wbSel, portSel
    );
endinterface

// File: rtl/ctrl_link_tracker.sv
// Link-stack occupancy tracker for call/return. Saturates at LR_DEPTH and
// never goes below zero; any overflow or underflow sets a sticky error.
module ctrl_link_tracker #(
    parameter int LR_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    output logic [$clog2(LR_DEPTH+1)-1:0] depth,
    output logic                          err
);
    localparam int D_W = $clog2(LR_DEPTH+1);

    // Occupancy counter with sticky over/underflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth <= '0;
            err   <= 1'b0;
        end else if (push) begin
            if (depth < D_W'(LR_DEPTH)) depth <= depth + D_W'(1);
            else                        err   <= 1'b1;
        end else if (pop) begin
            if (depth != '0) depth <= depth - D_W'(1);
            else             err   <= 1'b1;
        end
    end
endmodule

// File: rtl/mc_controller.sv
// Multi-cycle instruction controller: FETCH -> DECODE -> EXEC [-> MEM [-> WB]].
// Strobes are decoded from the current state and the opcode latched at fetch.
// Build option: define MC_CTRL_ILLEGAL_TRAP_EN to trap opcodes >= 16 into HALT;
// otherwise they execute as a no-op.
module mc_controller
    import ctrl_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int FLAG_W   = 2,
    parameter int LR_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mc_controller_if.master               bus,
    output logic [$clog2(LR_DEPTH+1)-1:0] lr_depth,
    output logic                          stack_err,
    output logic [2:0]                    state
);
    localparam int CI_W = $clog2(FLAG_W);

    state_t          st_q, st_d;
    logic [OP_W-1:0] op_q;
    logic [CI_W-1:0] ci_q;
    logic [3:0]      opc;
    logic            illegal;
    logic            push, pop, lr_empty;
    ctrl_strobes_t   s_c, s_o;

    assign opc      = op_q[3:0];
    assign lr_empty = (lr_depth == '0);

    generate
        if (OP_W > 4) begin : g_wide_op
            assign illegal = |op_q[OP_W-1:4];
        end else begin : g_narrow_op
            assign illegal = 1'b0;
        end
    endgenerate

    // Next-state and strobe decode
    always_comb begin
        st_d = st_q;
        s_c  = '0;
        push = 1'b0;
        pop  = 1'b0;
        case (st_q)
            ST_FETCH: begin
                s_c.ifetch = 1'b1;
                if (bus.mem_ready) begin
                    s_c.ir_we = 1'b1;
                    st_d      = ST_DECODE;
                end
            end
            ST_DECODE: st_d = ST_EXEC;
            ST_EXEC: begin
                st_d      = ST_FETCH;
                s_c.pc_we = 1'b1;
                if (illegal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    s_c.pc_we = 1'b0;
                    st_d      = ST_HALT;
`endif
                end else begin
                    case (opc)
                        OP_ADD, OP_SUB, OP_AND: begin
                            s_c.rfwe[RFWE_RF] = 1'b1;
                            s_c.rfwe[RFWE_Z]  = 1'b1;
                            s_c.rfwe[RFWE_N]  = 1'b1;
                        end
                        OP_OR, OP_XOR, OP_MOV: s_c.rfwe[RFWE_RF] = 1'b1;
                        OP_IN: begin
                            s_c.rfwe[RFWE_RF] = 1'b1;
                            s_c.portSel       = 1'b1;
                        end
                        OP_OUT: s_c.outwe = 1'b1;
                        OP_JMP: s_c.branchSel = BSEL_TGT;
                        OP_BCC: if (bus.flags[ci_q]) s_c.branchSel = BSEL_TGT;
                        OP_CALL: begin
                            s_c.branchSel     = BSEL_TGT;
                            s_c.rfwe[RFWE_LR] = 1'b1;
                            push              = 1'b1;
                        end
                        // Return on an empty link stack falls through to pc+2
                        OP_RET: begin
                            pop = 1'b1;
                            if (!lr_empty) s_c.branchSel = BSEL_LINK;
                        end
                        OP_LD, OP_ST: begin
                            s_c.pc_we = 1'b0;
                            st_d      = ST_MEM;
                        end
                        OP_LDI: begin
                            s_c.rfwe[RFWE_RF] = 1'b1;
                            s_c.wbSel         = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_MEM: begin
                if (opc == OP_LD) s_c.dmre = 1'b1;
                else              s_c.dmwe = 1'b1;
                if (bus.mem_ready) begin
                    if (opc == OP_LD) begin
                        st_d = ST_WB;
                    end else begin
                        s_c.pc_we = 1'b1;
                        st_d      = ST_FETCH;
                    end
                end
            end
            ST_WB: begin
                s_c.rfwe[RFWE_RF] = 1'b1;
                s_c.wbSel         = 1'b1;
                s_c.pc_we         = 1'b1;
                st_d              = ST_FETCH;
            end
            ST_HALT: ;
            default: st_d = ST_FETCH;
        endcase
    end

    // State register and opcode/condition latch at fetch completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q <= ST_FETCH;
            op_q <= '0;
            ci_q <= '0;
        end else begin
            st_q <= st_d;
            if (s_c.ir_we) begin
                op_q <= bus.op;
                ci_q <= bus.cond_idx;
            end
        end
    end

    // Strobes are forced low for as long as reset is held, not just after an edge
    assign s_o = rst_n ? s_c : '0;

    assign bus.ifetch    = s_o.ifetch;
    assign bus.ir_we     = s_o.ir_we;
    assign bus.pc_we     = s_o.pc_we;
    assign bus.rfwe      = s_o.rfwe;
    assign bus.dmwe      = s_o.dmwe;
    assign bus.dmre      = s_o.dmre;
    assign bus.outwe     = s_o.outwe;
    assign bus.branchSel = s_o.branchSel;
    assign bus.wbSel     = s_o.wbSel;
    assign bus.portSel   = s_o.portSel;
    assign state         = st_q;

    ctrl_link_tracker #(.LR_DEPTH(LR_DEPTH)) u_link (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .depth (lr_depth),
        .err   (stack_err)
    );
endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the driver plays instruction/data memory
// and pushes the expected per-instruction outcome; a monitor pops and compares
// at every pc_we. Build option MC_CTRL_ILLEGAL_TRAP_EN is honoured.
module tb_mc_controller;
    localparam int OP_W     = 5;
    localparam int FLAG_W   = 2;
    localparam int LR_DEPTH = 4;
    localparam int ST_FETCH_C = 0;
    localparam int ST_HALT_C  = 5;

    typedef struct {
        int rfwe; int bs; int wb; int ps; int ow;
        int lat;  int nrd; int nwr; int depth; int err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] lr_depth;
    logic       stack_err;
    logic [2:0] state;

    mc_controller_if #(.OP_W(OP_W), .FLAG_W(FLAG_W)) bus ();

    mc_controller #(.OP_W(OP_W), .FLAG_W(FLAG_W), .LR_DEPTH(LR_DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .lr_depth  (lr_depth),
        .stack_err (stack_err),
        .state     (state)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q[$];
    bit   mon_en = 1'b0;
    int   exp_depth = 0;
    int   exp_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout/unexpected event, expected DUT response (t=%0t)", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: per-instruction bookkeeping, compared when the instruction retires
    initial begin : monitor
        int   lat_cnt, nrd, nwr, stray;
        bit   dep_pend;
        exp_t e, held;
        lat_cnt = 0; nrd = 0; nwr = 0; stray = 0; dep_pend = 1'b0;
        forever begin
            @(negedge clk);
            if (dep_pend) begin
                chk("lr_depth", int'(lr_depth), held.depth);
                chk("stack_err", int'(stack_err), held.err);
                chk("ifetch_after_retire", int'(bus.ifetch), 1);
                dep_pend = 1'b0;
            end
            if (mon_en && rst_n) begin
                if (bus.ir_we) begin
                    lat_cnt = 0; nrd = 0; nwr = 0; stray = 0;
                end else begin
                    lat_cnt++;
                end
                if (bus.dmre) nrd++;
                if (bus.dmwe) nwr++;
                if (!bus.pc_we && (bus.rfwe != 4'd0 || bus.outwe || bus.wbSel ||
                                   bus.portSel || bus.branchSel != 2'd0))
                    stray++;
                if (bus.pc_we) begin
                    if (q.size() == 0) begin
                        fail_now("pc_we_without_instruction");
                    end else begin
                        e = q.pop_front();
                        chk("rfwe", int'(bus.rfwe), e.rfwe);
                        chk("branchSel", int'(bus.branchSel), e.bs);
                        chk("wbSel", int'(bus.wbSel), e.wb);
                        chk("portSel", int'(bus.portSel), e.ps);
                        chk("outwe", int'(bus.outwe), e.ow);
                        chk("latency", lat_cnt, e.lat);
                        chk("dmre_cycles", nrd, e.nrd);
                        chk("dmwe_cycles", nwr, e.nwr);
                        chk("stray_strobes", stray, 0);
                        held = e;
                        dep_pend = 1'b1;
                    end
                end
            end
        end
    end

    // Driver + reference model: fetch one instruction and push its outcome
    task automatic issue(input int o, input int ci, input int fl, input int wf, input int wm);
        int   n;
        exp_t e;
        int   oc;
        n = 0;
        while (!bus.ifetch && n < 20) begin step(); n++; end
        if (!bus.ifetch) begin fail_now("fetch_wait"); return; end
        oc = (o >= 16) ? 0 : o;
        e = '{default: 0};
        e.lat = 2;
        case (oc)
            1, 2, 3:    e.rfwe = 7;
            4, 5, 8:    e.rfwe = 1;
            6:          e.ow = 1;
            7:          begin e.rfwe = 1; e.ps = 1; end
            9:          e.bs = 1;
            10:         e.bs = (fl >> ci) & 1;
            11: begin
                e.bs = 1; e.rfwe = 8;
                if (exp_depth < LR_DEPTH) exp_depth++; else exp_err = 1;
            end
            12: begin
                if (exp_depth > 0) begin e.bs = 2; exp_depth--; end
                else exp_err = 1;
            end
            13:         begin e.rfwe = 1; e.wb = 1; e.nrd = wm + 1; e.lat = wm + 4; end
            14:         begin e.nwr = wm + 1; e.lat = wm + 3; end
            15:         begin e.rfwe = 1; e.wb = 1; end
            default: ;
        endcase
        e.depth = exp_depth;
        e.err   = exp_err;
        q.push_back(e);
        bus.op       = OP_W'(o);
        bus.cond_idx = 1'(ci);
        bus.flags    = FLAG_W'(fl);
        bus.mem_ready = 1'b0;
        repeat (wf) step();
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        // scramble the bus so only the latched copies can be used
        bus.op       = OP_W'($urandom);
        bus.cond_idx = 1'($urandom);
        if (oc == 13 || oc == 14) begin
            n = 0;
            while (!(bus.dmre || bus.dmwe) && n < 10) begin step(); n++; end
            if (!(bus.dmre || bus.dmwe)) begin fail_now("mem_wait"); return; end
            repeat (wm) step();
            bus.mem_ready = 1'b1;
            step();
            bus.mem_ready = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!bus.ifetch && n < 20) begin step(); n++; end
        if (!bus.ifetch) fail_now("drain_wait");
        step();
        chk("queue_drained", q.size(), 0);
    endtask

    initial begin : main
        int n;
        rst_n = 1'b0;
        bus.op = '0; bus.flags = '0; bus.cond_idx = '0; bus.mem_ready = 1'b0;
        #12;
        chk("rst_state", int'(state), ST_FETCH_C);
        chk("rst_ifetch", int'(bus.ifetch), 0);
        chk("rst_lr_depth", int'(lr_depth), 0);
        chk("rst_stack_err", int'(stack_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("first_ifetch", int'(bus.ifetch), 1);
        mon_en = 1'b1;

        // return on empty link stack
        issue(12, 0, 0, 0, 0);
        // five calls overflow a 4-deep stack, then one return
        for (int i = 0; i < 5; i++) issue(11, 0, 0, i % 2, 0);
        issue(12, 0, 0, 0, 0);
        // single-cycle fetch ALU op, load with 3 wait cycles, conditional branch
        issue(1, 0, 0, 0, 0);
        issue(13, 0, 0, 0, 3);
        issue(10, 1, 2, 0, 0);
        issue(10, 1, 1, 1, 0);
        issue(14, 0, 0, 2, 1);
        issue(7, 0, 0, 0, 0);
        issue(6, 0, 0, 0, 0);
        issue(15, 0, 0, 0, 0);

        // randomized instruction stream
        for (int i = 0; i < 250; i++) begin
            int o;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            o = int'($urandom_range(15, 0));
`else
            o = int'($urandom_range(31, 0));
`endif
            issue(o, int'($urandom_range(1, 0)), int'($urandom_range(3, 0)),
                  int'($urandom_range(2, 0)), int'($urandom_range(3, 0)));
        end
        drain();
        mon_en = 1'b0;

        // asynchronous reset in the middle of a store handshake
        n = 0;
        while (!bus.ifetch && n < 20) begin step(); n++; end
        bus.op = OP_W'(14);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        n = 0;
        while (!bus.dmwe && n < 10) begin step(); n++; end
        chk("store_in_mem", int'(bus.dmwe), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_dmwe", int'(bus.dmwe), 0);
        chk("midrst_state", int'(state), ST_FETCH_C);
        chk("midrst_lr_depth", int'(lr_depth), 0);
        chk("midrst_stack_err", int'(stack_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_depth = 0;
        exp_err = 0;
        #1;
        chk("midrst_ifetch", int'(bus.ifetch), 1);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        // illegal opcode traps into HALT and stays silent
        bus.op = OP_W'(20);
        bus.mem_ready = 1'b1;
        step();
        bus.mem_ready = 1'b0;
        step();
        step();
        repeat (4) begin
            chk("halt_state", int'(state), ST_HALT_C);
            chk("halt_ifetch", int'(bus.ifetch), 0);
            chk("halt_pc_we", int'(bus.pc_we), 0);
            step();
        end
`else
        // illegal opcode executes as a no-op
        mon_en = 1'b1;
        issue(20, 0, 0, 0, 0);
        issue(2, 0, 0, 1, 0);
        drain();
        mon_en = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule
